nibble_unpack_fifo: RTL and testbench

- Byte-in, nibble-out buffer; the write side accepts 8-bit bytes, the read side delivers 4-bit nibbles, low nibble first.
- It is the opposite-direction companion of the team's nibble-packing FIFO, which takes 4-bit nibbles and delivers 8-bit bytes.
- It sits between a byte-wide producer and a 4-bit serial or parallel consumer.
- Single clock domain; storage is a DEPTH-entry byte RAM with circular pointers.

---
 rtl/nibble_unpack_fifo.sv | 97 +++++++++
 tb/tb_nibble_unpack_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_unpack_fifo.sv
// nibble_unpack_fifo: byte-in, nibble-out FIFO over a DEPTH-entry byte RAM.
// Ports: clk, rst_n (async low); write side Data_In/input_enable/input_valid;
// read side Data_Out/output_enable/output_valid; level (bytes held), overflow
// (sticky dropped-write flag). Define NIBBLE_MSB_FIRST_EN for high nibble first.
module nibble_unpack_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    Data_In,
  input  logic          input_enable,
  output logic          input_valid,
  output logic [3:0]    Data_Out,
  input  logic          output_enable,
  output logic          output_valid,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  logic [7:0]    r_ram [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_half;
  logic          r_overflow;

  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_rd;
  logic          w_pop_hi;
  logic [7:0]    w_byte;
  logic [3:0]    w_first;
  logic [3:0]    w_second;

  assign w_full   = (r_count == LP_FULL);
  assign w_empty  = (r_count == '0);
  // Fullness is judged on the start-of-cycle count, so a same-cycle
  // high-nibble pop never rescues a write into a full buffer.
  assign w_wr     = input_enable & ~w_full;
  assign w_rd     = output_enable & ~w_empty;
  assign w_pop_hi = w_rd & r_half;

  assign w_byte   = r_ram[r_rd_ptr];

`ifdef NIBBLE_MSB_FIRST_EN
  assign w_first  = w_byte[7:4];
  assign w_second = w_byte[3:0];
`else
  assign w_first  = w_byte[3:0];
  assign w_second = w_byte[7:4];
`endif

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_ram[r_wr_ptr] <= Data_In;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_half     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (input_enable && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_rd) begin
        r_half <= ~r_half;
      end
      if (w_pop_hi) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({w_wr, w_pop_hi})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign input_valid  = ~w_full;
  assign output_valid = ~w_empty;
  assign level        = r_count;
  assign overflow     = r_overflow;
  assign Data_Out     = w_empty ? 4'h0 : (r_half ? w_second : w_first);

endmodule

// File: tb/tb_nibble_unpack_fifo.sv
// tb_nibble_unpack_fifo: table-driven vectors plus a nibble scoreboard
// for nibble_unpack_fifo, with hand-written reset and ordering sequences.
module tb_nibble_unpack_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] Data_In = 8'h00;
  logic       input_enable = 1'b0;
  logic       input_valid;
  logic [3:0] Data_Out;
  logic       output_enable = 1'b0;
  logic       output_valid;
  logic [3:0] level;
  logic       overflow;

  nibble_unpack_fifo #(.DEPTH(DEPTH), .AW(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Data_In      (Data_In),
    .input_enable (input_enable),
    .input_valid  (input_valid),
    .Data_Out     (Data_Out),
    .output_enable(output_enable),
    .output_valid (output_valid),
    .level        (level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         wr;
    logic [7:0] din;
    bit         rd;
    int         exp_level;
    bit         exp_ovf;
  } vec_t;

  vec_t vq[$];
  logic [3:0] sbq[$];
  int  m_cnt;
  bit  m_half;
  bit  m_ovf;
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic void add(bit r, bit w, logic [7:0] d, bit rd,
                              int lvl, bit ov);
    vec_t v;
    v.rst = r;
    v.wr = w;
    v.din = d;
    v.rd = rd;
    v.exp_level = lvl;
    v.exp_ovf = ov;
    vq.push_back(v);
  endfunction

  function automatic logic [3:0] first_nib(logic [7:0] b);
`ifdef NIBBLE_MSB_FIRST_EN
    return b[7:4];
`else
    return b[3:0];
`endif
  endfunction

  function automatic logic [3:0] second_nib(logic [7:0] b);
`ifdef NIBBLE_MSB_FIRST_EN
    return b[3:0];
`else
    return b[7:4];
`endif
  endfunction

  function automatic void model_clear();
    sbq.delete();
    m_cnt = 0;
    m_half = 1'b0;
    m_ovf = 1'b0;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit wr, input logic [7:0] d, input bit rd);
    bit wok;
    bit rok;
    logic [3:0] e;
    input_enable = wr;
    Data_In = d;
    output_enable = rd;
    #1;
    wok = wr && (m_cnt != DEPTH);
    rok = rd && (m_cnt != 0);
    if (wr && !wok) m_ovf = 1'b1;
    if (rok) begin
      e = sbq.pop_front();
      chk("pop_nibble", int'(Data_Out), int'(e));
      if (m_half) m_cnt--;
      m_half = ~m_half;
    end
    if (wok) begin
      sbq.push_back(first_nib(d));
      sbq.push_back(second_nib(d));
      m_cnt++;
    end
    @(posedge clk);
    #1;
    input_enable = 1'b0;
    output_enable = 1'b0;
    chk("level", int'(level), m_cnt);
    chk("input_valid", int'(input_valid), int'(m_cnt != DEPTH));
    chk("output_valid", int'(output_valid), int'(m_cnt != 0));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("head", int'(Data_Out), (sbq.size() == 0) ? 0 : int'(sbq[0]));
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_ov", int'(output_valid), 0);
    chk("rst_dout", int'(Data_Out), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_iv", int'(input_valid), 1);
    chk("rst_ovf", int'(overflow), 0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    model_clear();
    // Table: fill, overflow, drain, full+hi-pop, wrap, corners.
    for (int i = 0; i < 8; i++) add(0, 1, 8'h10 + 8'(i), 0, i + 1, 0);
    add(0, 1, 8'hFF, 0, 8, 1);
    for (int k = 1; k <= 15; k++) add(0, 0, 8'h00, 1, 8 - k / 2, 1);
    for (int i = 0; i < 7; i++) add(0, 1, 8'h20 + 8'(i), 0, 2 + i, 1);
    add(0, 1, 8'h3C, 1, 7, 1);
    add(0, 1, 8'h3C, 0, 8, 1);
    for (int k = 1; k <= 16; k++) add(0, 0, 8'h00, 1, 8 - k / 2, 1);
    add(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      add(0, 1, 8'h5A + 8'(i * 19), 0, 1, 0);
      add(0, 0, 8'h00, 1, 1, 0);
      add(0, 0, 8'h00, 1, 0, 0);
    end
    add(0, 1, 8'hC7, 0, 1, 0);
    add(0, 1, 8'hB6, 1, 2, 0);
    add(0, 0, 8'h00, 1, 1, 0);
    add(0, 0, 8'h00, 1, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0);
    add(0, 1, 8'hD8, 1, 1, 0);
    add(0, 0, 8'h00, 1, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0);

    // Reset then idle.
    #3;
    chk("idle_iv", int'(input_valid), 1);
    chk("idle_ov", int'(output_valid), 0);
    chk("idle_dout", int'(Data_Out), 0);
    chk("idle_level", int'(level), 0);
    chk("idle_ovf", int'(overflow), 0);
    #4;
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte, nibble order.
    step(1, 8'hA5, 0);
`ifdef NIBBLE_MSB_FIRST_EN
    chk("a5_first", int'(Data_Out), 4'hA);
`else
    chk("a5_first", int'(Data_Out), 4'h5);
`endif
    step(0, 8'h00, 1);
`ifdef NIBBLE_MSB_FIRST_EN
    chk("a5_second", int'(Data_Out), 4'h5);
`else
    chk("a5_second", int'(Data_Out), 4'hA);
`endif
    step(0, 8'h00, 1);
    chk("a5_empty", int'(output_valid), 0);

    foreach (vq[i]) begin
      if (vq[i].rst) begin
        pulse_reset();
      end else begin
        step(vq[i].wr, vq[i].din, vq[i].rd);
        chk($sformatf("vec%0d_level", i), int'(level), vq[i].exp_level);
        chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vq[i].exp_ovf));
      end
    end

    // Async reset after a half-consumed byte.
    step(1, 8'h9E, 0);
    step(0, 8'h00, 1);
    #2;
    pulse_reset();
    step(1, 8'h42, 0);
`ifdef NIBBLE_MSB_FIRST_EN
    chk("x42_first", int'(Data_Out), 4'h4);
`else
    chk("x42_first", int'(Data_Out), 4'h2);
`endif
    step(0, 8'h00, 1);
`ifdef NIBBLE_MSB_FIRST_EN
    chk("x42_second", int'(Data_Out), 4'h2);
`else
    chk("x42_second", int'(Data_Out), 4'h4);
`endif
    step(0, 8'h00, 1);
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
